// File: rtl/rf_pkg.sv
// Shared constants for the register-file ALU controller: widths, opcodes, FSM states.
package rf_pkg;

    localparam int RF_DW = 8;
    localparam int RF_AW = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RDA  = 3'd1,
        ST_RDB  = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } rf_state_e;

endpackage

// File: rtl/rf_alu.sv
// Combinational ALU: result modulo 2^DW plus zero and carry/borrow flags.
module rf_alu
    import rf_pkg::*;
#(
    parameter int DW = RF_DW
) (
    input  logic [2:0]    op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] imm_i,
    output logic [DW-1:0] result_o,
    output logic          zero_o,
    output logic          carry_o
);

    logic [DW:0] add_w;
    logic [DW:0] sub_w;

    // Extended add/sub so the top bit is the carry-out / borrow.
    assign add_w = {1'b0, a_i} + {1'b0, b_i};
    assign sub_w = {1'b0, a_i} - {1'b0, b_i};

    // Opcode decode; only ADD, SUB and SHL produce a carry.
    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = add_w[DW-1:0];
                carry_o  = add_w[DW];
            end
            OP_SUB: begin
                result_o = sub_w[DW-1:0];
                carry_o  = sub_w[DW];
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_LDI: result_o = imm_i;
            OP_SHL: begin
                result_o = {a_i[DW-2:0], 1'b0};
                carry_o  = a_i[DW-1];
            end
            default: begin
                result_o = '0;
                carry_o  = 1'b0;
            end
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/regfile_alu_ctrl.sv
// Sequencer that reads two registers, runs the ALU and writes the result back.
// Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
// are both 1; cmd_ready is 1 only in IDLE, so cmd_valid is ignored elsewhere.
// Register file read data (rf_q) arrives one cycle after rf_rsel.
module regfile_alu_ctrl
    import rf_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic [AW-1:0] cmd_rd,
    input  logic [DW-1:0] cmd_imm,
    output logic [AW-1:0] rf_rsel,
    input  logic [DW-1:0] rf_q,
    output logic          rf_wen,
    output logic [AW-1:0] rf_wsel,
    output logic [DW-1:0] rf_d,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic          res_zero,
    output logic          res_carry,
    output logic [2:0]    dbg_state
);

    rf_state_e     state_q, state_d;
    logic [2:0]    op_q;
    logic [AW-1:0] ra_q, rb_q, rd_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] a_q;
    logic [AW-1:0] rsel_q;
    logic [DW-1:0] res_data_q;
    logic          res_zero_q, res_carry_q;

    logic [DW-1:0] alu_result;
    logic          alu_zero, alu_carry;
    logic          accept;

    assign accept = cmd_valid && (state_q == ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: fixed five-cycle walk once a command is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RDA;
            ST_RDA:  state_d = ST_RDB;
            ST_RDB:  state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs; writes happen only in WB and never for NOP.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        res_valid = (state_q == ST_WB);
        rf_wen    = (state_q == ST_WB) && (op_q != OP_NOP);
    end

    // Command latch, read-select sequencing, operand A capture, result register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            op_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            a_q         <= '0;
            rsel_q      <= '0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_carry_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    op_q   <= cmd_op;
                    ra_q   <= cmd_ra;
                    rb_q   <= cmd_rb;
                    rd_q   <= cmd_rd;
                    imm_q  <= cmd_imm;
                    rsel_q <= cmd_ra;
                end
                ST_RDA:  rsel_q <= rb_q;
                ST_RDB:  a_q    <= rf_q;
                ST_EXEC: begin
                    res_data_q  <= alu_result;
                    res_zero_q  <= alu_zero;
                    res_carry_q <= alu_carry;
                end
                default: ;
            endcase
        end
    end

    // rf_q holds operand B during EXEC.
    rf_alu #(.DW(DW)) u_alu (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (rf_q),
        .imm_i    (imm_q),
        .result_o (alu_result),
        .zero_o   (alu_zero),
        .carry_o  (alu_carry)
    );

    assign rf_rsel   = rsel_q;
    assign rf_wsel   = rd_q;
    assign rf_d      = res_data_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign res_carry = res_carry_q;
    assign dbg_state = state_q;

    // ra_q is only needed to load rsel_q on accept; keep it observable for checkers.
    logic unused_ra;
    assign unused_ra = ^ra_q;

endmodule

// File: tb/tb_regfile_alu_ctrl.sv
// Directed bench: a behavioural register file feeds the controller, a driver
// issues commands and pushes hand-computed results, a monitor pops and compares.
module tb_regfile_alu_ctrl;
    import rf_pkg::*;

    localparam int DW = RF_DW;
    localparam int AW = RF_AW;
    localparam int EW = 1 + AW + 2 + DW;

    logic          clk = 1'b0;
    logic          clrn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_ra, cmd_rb, cmd_rd;
    logic [DW-1:0] cmd_imm;
    logic [AW-1:0] rf_rsel;
    logic [DW-1:0] rf_q;
    logic          rf_wen;
    logic [AW-1:0] rf_wsel;
    logic [DW-1:0] rf_d;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_zero, res_carry;
    logic [2:0]    dbg_state;

    logic [DW-1:0] mem [8];
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc1, acc2, acc_dummy;

    regfile_alu_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .clrn(clrn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
        .rf_rsel(rf_rsel), .rf_q(rf_q),
        .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_d(rf_d),
        .res_valid(res_valid), .res_data(res_data), .res_zero(res_zero), .res_carry(res_carry),
        .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // register file: registered read, synchronous write
    initial for (int i = 0; i < 8; i++) mem[i] = '0;
    always @(posedge clk) begin
        rf_q <= mem[rf_rsel];
        if (rf_wen) mem[rf_wsel] <= rf_d;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_cmd_ready"}, 16'(cmd_ready), 16'd1);
        check({tag, "_state"},     16'(dbg_state), 16'(ST_IDLE));
        check({tag, "_rf_wen"},    16'(rf_wen), 16'd0);
        check({tag, "_rf_wsel"},   16'(rf_wsel), 16'd0);
        check({tag, "_rf_d"},      16'(rf_d), 16'd0);
        check({tag, "_rf_rsel"},   16'(rf_rsel), 16'd0);
        check({tag, "_res_valid"}, 16'(res_valid), 16'd0);
        check({tag, "_res_data"},  16'(res_data), 16'd0);
        check({tag, "_res_zero"},  16'(res_zero), 16'd0);
        check({tag, "_res_carry"}, 16'(res_carry), 16'd0);
    endtask

    // driver: offer one command, optionally pushing its expected result
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic [AW-1:0] rd, input logic [DW-1:0] imm, input bit expect_res,
                         input logic [DW-1:0] ed, input logic ez, input logic ec,
                         input bit hold, output int acc);
        int n;
        if (expect_res) exp_q.push_back({(op != OP_NOP), rd, ez, ec, ed});
        @(negedge clk);
        cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_imm = imm;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        acc = -1;
        if (!cmd_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: cmd_ready stayed %b, required 1", cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            acc = cyc;
            #1;
            if (!hold) cmd_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // monitor: compare each result report against the head of the expected queue
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (clrn === 1'b1) begin
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL res_valid_unexpected: res_valid=1 with no command pending, required 0");
                end else begin
                    e = exp_q.pop_front();
                    check("wb_report", 16'({rf_wen, rf_wsel, res_zero, res_carry, res_data}), 16'(e));
                    check("wb_rf_d", 16'(rf_d), 16'(e[DW-1:0]));
                end
            end else if (rf_wen) begin
                n_cmp++;
                n_err++;
                $display("FAIL wen_outside_wb: rf_wen=1 with res_valid=0, required 0");
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0; cmd_imm = '0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        clrn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 16'(cmd_ready), 16'd1);

        // LDI then ADD: 5A + A5 = FF
        issue(OP_LDI, 3'd0, 3'd0, 3'd1, 8'h5A, 1, 8'h5A, 1'b0, 1'b0, 0, acc_dummy);
        issue(OP_LDI, 3'd0, 3'd0, 3'd2, 8'hA5, 1, 8'hA5, 1'b0, 1'b0, 0, acc_dummy);
        issue(OP_ADD, 3'd1, 3'd2, 3'd3, 8'h00, 1, 8'hFF, 1'b0, 1'b0, 0, acc_dummy);
        // ADD overflow: 80 + 80 = 00 with carry
        issue(OP_LDI, 3'd0, 3'd0, 3'd1, 8'h80, 1, 8'h80, 1'b0, 1'b0, 0, acc_dummy);
        issue(OP_LDI, 3'd0, 3'd0, 3'd2, 8'h80, 1, 8'h80, 1'b0, 1'b0, 0, acc_dummy);
        issue(OP_ADD, 3'd1, 3'd2, 3'd4, 8'h00, 1, 8'h00, 1'b1, 1'b1, 0, acc_dummy);
        // SUB with borrow: 05 - 07 = FE; SHL FE = FC with carry
        issue(OP_LDI, 3'd0, 3'd0, 3'd1, 8'h05, 1, 8'h05, 1'b0, 1'b0, 0, acc_dummy);
        issue(OP_LDI, 3'd0, 3'd0, 3'd2, 8'h07, 1, 8'h07, 1'b0, 1'b0, 0, acc_dummy);
        issue(OP_SUB, 3'd1, 3'd2, 3'd5, 8'h00, 1, 8'hFE, 1'b0, 1'b1, 0, acc_dummy);
        issue(OP_SHL, 3'd5, 3'd0, 3'd5, 8'h00, 1, 8'hFC, 1'b0, 1'b1, 0, acc_dummy);
        // logic ops: FF & FC, 05 | 07, 05 ^ 07
        issue(OP_AND, 3'd3, 3'd5, 3'd0, 8'h00, 1, 8'hFC, 1'b0, 1'b0, 0, acc_dummy);
        issue(OP_OR,  3'd1, 3'd2, 3'd0, 8'h00, 1, 8'h07, 1'b0, 1'b0, 0, acc_dummy);
        issue(OP_XOR, 3'd1, 3'd2, 3'd0, 8'h00, 1, 8'h02, 1'b0, 1'b0, 0, acc_dummy);
        drain();

        // back-to-back with cmd_valid held: second reads the first one's rd (33 + 05)
        issue(OP_LDI, 3'd0, 3'd0, 3'd6, 8'h33, 1, 8'h33, 1'b0, 1'b0, 1, acc1);
        issue(OP_ADD, 3'd6, 3'd1, 3'd7, 8'h00, 1, 8'h38, 1'b0, 1'b0, 0, acc2);
        check("b2b_accept_spacing", 16'(acc2 - acc1), 16'd5);
        drain();
        check("b2b_r7_written", 16'(mem[7]), 16'h38);

        // NOP: reports zero, writes nothing
        issue(OP_NOP, 3'd1, 3'd2, 3'd3, 8'h00, 1, 8'h00, 1'b1, 1'b0, 0, acc_dummy);
        drain();
        check("nop_r3_kept", 16'(mem[3]), 16'hFF);

        // reset during EXEC drops the command (would write 0A to r2)
        issue(OP_ADD, 3'd1, 3'd1, 3'd2, 8'h00, 0, 8'h00, 1'b0, 1'b0, 0, acc_dummy);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("in_exec_before_reset", 16'(dbg_state), 16'(ST_EXEC));
        #1;
        clrn = 1'b0;
        #1;
        check_cleared("exec_reset");
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        check("ready_after_exec_reset", 16'(cmd_ready), 16'd1);
        repeat (6) @(negedge clk);
        check("exec_reset_r2_kept", 16'(mem[2]), 16'h07);

        // normal operation after the aborted command
        issue(OP_ADD, 3'd1, 3'd2, 3'd0, 8'h00, 1, 8'h0C, 1'b0, 1'b0, 0, acc_dummy);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_alu_ctrl.md
REGFILE_ALU_CTRL -- requirements
Module: regfile_alu_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, data width matching the 8-entry register file.
REQ-002 SHALL have parameter AW, default 3, register address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clrn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1, command offered.
REQ-006 SHALL have port cmd_ready, output, 1, controller accepts a command this cycle.
REQ-007 SHALL have ports cmd_op input 3, cmd_ra input AW, cmd_rb input AW, cmd_rd input AW and cmd_imm input DW, carrying opcode, sources, destination and immediate.
REQ-008 SHALL have port rf_rsel, output, AW, read select to the register file.
REQ-009 SHALL have port rf_q, input, DW, registered read data from the register file, one cycle after rf_rsel.
REQ-010 SHALL have ports rf_wen output 1, rf_wsel output AW and rf_d output DW, the register-file write port.
REQ-011 SHALL have ports res_valid output 1, res_data output DW, res_zero output 1 and res_carry output 1, the result report.

Function
REQ-012 SHALL implement states IDLE, RDA, RDB, EXEC and WB, with cmd_ready=1 only in IDLE.
REQ-013 SHALL, in IDLE on cmd_valid&cmd_ready, latch op/ra/rb/rd/imm and go to RDA; otherwise it SHALL stay in IDLE.
REQ-014 SHALL drive rf_rsel=ra in RDA and rf_rsel=rb in RDB; in other states rf_rsel SHALL hold its last value, and it SHALL be 0 after reset.
REQ-015 SHALL capture operand A from rf_q at the end of RDB, and use rf_q in EXEC as operand B.
REQ-016 SHALL, in EXEC, compute the result and register it with its flags: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 LDI (result=imm), 110 SHL (A<<1), 111 NOP.
REQ-017 SHALL compute the result modulo 2^DW; res_carry SHALL be the ADD carry-out, the SUB borrow (A<B) or SHL A[DW-1], and 0 for every other op.
REQ-018 SHALL set res_zero=1 iff the result is 0, with NOP giving result 0 and res_zero=1.
REQ-019 SHALL, in WB, assert rf_wen=1 with rf_wsel=rd and rf_d=result, except for NOP (rf_wen=0).
REQ-020 SHALL, in WB, pulse res_valid for exactly one cycle; res_data and the flags SHALL hold until the next WB.
REQ-021 SHALL move WB to IDLE unconditionally, giving an accept-to-writeback latency of 4 cycles and a throughput of one command per 5 cycles.
REQ-022 SHALL guarantee that a command accepted after WB reads values already written, because writes complete before the next RDA; rd==ra or rd==rb needs no forwarding.
REQ-023 SHALL keep rf_wen=0 in every state other than WB.
REQ-024 SHALL ignore cmd_valid, without latching, while not in IDLE.

Reset
REQ-025 SHALL, while clrn=0, asynchronously force IDLE, rf_wen=0, rf_wsel=0, rf_d=0, rf_rsel=0, res_valid=0, res_data=0, res_zero=0, res_carry=0 and latched fields 0.
REQ-026 SHALL drop an in-flight command on reset at any state without issuing a write; after release, cmd_ready=1 on the first cycle.

Structure
REQ-027 SHALL define opcode constants, state encodings and DW/AW defaults in a shared package rf_pkg, used by this block and its bench.
REQ-028 SHALL contain exactly one sub-module, rf_alu: combinational, taking op, A, B and imm, producing result, zero and carry.

Verification
REQ-029 SHALL cover: reset, then LDI r1=0x5A and LDI r2=0xA5, then ADD r3=r1+r2 -> rf_d=0xFF, res_zero=0, res_carry=0, rf_wen in WB with rf_wsel=3.
REQ-030 SHALL cover: r1=0x80 and r2=0x80, ADD r4 -> res_data=0x00, res_zero=1, res_carry=1.
REQ-031 SHALL cover: r1=0x05 and r2=0x07, SUB r5=r1-r2 -> 0xFE with carry=1; then SHL r5 -> 0xFC with carry=1.
REQ-032 SHALL cover: back-to-back commands with cmd_valid held high -> accepts exactly 5 cycles apart, and the second command with ra=previous rd reads the new value.
REQ-033 SHALL cover: NOP -> res_valid pulses, rf_wen stays 0, and register contents are unchanged.
REQ-034 SHALL cover: clrn low during EXEC -> no rf_wen, all outputs 0, and cmd_ready=1 the cycle after release.
